// File: rtl/dvs_pkg.sv
// Shared types for the DVS event path: the decoded event record and the packet decoder states.
package dvs_pkg;

  localparam logic [7:0] DVS_SYNC_BYTE = 8'hA5;

  typedef struct packed {
    logic [7:0] x;
    logic [7:0] y;
    logic       pol;
  } dvs_event_t;

  typedef enum logic [2:0] {HUNT, X, Y, FLAGS, CSUM} dec_state_e;

endpackage

// File: rtl/event_fifo.sv
// Show-ahead synchronous FIFO of decoded DVS events; the head entry is visible while not empty.
module event_fifo
  import dvs_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  dvs_event_t push_data,
  output logic       full,
  input  logic       pop,
  output dvs_event_t head,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  dvs_event_t    mem_q [DEPTH];
  logic          do_push, do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign head    = mem_q[rd_ptr_q];

  // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; validity comes from count_q and the top masks the head when empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/uart_event_decoder.sv
// Reassembles 5-byte DVS packets from a UART byte stream, validates them and buffers good events.
module uart_event_decoder
  import dvs_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE    = DVS_SYNC_BYTE,
  parameter int         SENSOR_W     = 128,
  parameter int         SENSOR_H     = 128,
  parameter int         TIMEOUT_CLKS = 2080,
  parameter int         FIFO_DEPTH   = 4,
  parameter int         ERR_CNT_W    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           in_data,
  input  logic                 in_valid,
  output logic [7:0]           ev_x,
  output logic [7:0]           ev_y,
  output logic                 ev_pol,
  output logic                 ev_valid,
  input  logic                 ev_ready,
  output logic [ERR_CNT_W-1:0] csum_err,
  output logic [ERR_CNT_W-1:0] frame_err,
  output logic [ERR_CNT_W-1:0] range_err,
  output logic [ERR_CNT_W-1:0] ovf_err
);

  localparam int TW = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT_CLKS - 1);

  dec_state_e           state_q, state_d;
  logic [7:0]           x_q, x_d, y_q, y_d, csum_q, csum_d;
  logic                 pol_q, pol_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [ERR_CNT_W-1:0] csum_err_q, csum_err_d, frame_err_q, frame_err_d;
  logic [ERR_CNT_W-1:0] range_err_q, range_err_d, ovf_err_q, ovf_err_d;

  logic       timed_out, out_of_range, push, pop;
  logic       inc_csum, inc_frame, inc_range, inc_ovf;
  logic       fifo_full, fifo_empty;
  dvs_event_t fifo_head;

  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v, input logic en);
    return (en && (v != '1)) ? v + ERR_CNT_W'(1) : v;
  endfunction

  // Widened compare keeps SENSOR_W/H = 256 meaningful for 8-bit coordinates.
  assign out_of_range = ({1'b0, x_q} >= 9'(SENSOR_W)) || ({1'b0, y_q} >= 9'(SENSOR_H));
  assign timed_out    = (state_q != HUNT) && !in_valid && (timer_q == TIMER_MAX);

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    pol_d     = pol_q;
    csum_d    = csum_q;
    push      = 1'b0;
    inc_csum  = 1'b0;
    inc_range = 1'b0;
    inc_frame = 1'b0;

    if (in_valid || (state_q == HUNT) || timed_out) timer_d = '0;
    else                                            timer_d = timer_q + TW'(1);

    if (timed_out) begin
      state_d   = HUNT;
      inc_frame = 1'b1;
    end else if (in_valid) begin
      case (state_q)
        HUNT:  if (in_data == SYNC_BYTE) state_d = X;
        X: begin
          x_d     = in_data;
          csum_d  = in_data;
          state_d = Y;
        end
        Y: begin
          y_d     = in_data;
          csum_d  = csum_q ^ in_data;
          state_d = FLAGS;
        end
        FLAGS: begin
          pol_d   = in_data[7];
          csum_d  = csum_q ^ in_data;
          state_d = CSUM;
        end
        CSUM: begin
          state_d = HUNT;
          if (in_data != csum_q) inc_csum  = 1'b1;
          else if (out_of_range) inc_range = 1'b1;
          else                   push      = 1'b1;
        end
        default: state_d = HUNT;
      endcase
    end
  end

  assign pop     = ev_valid && ev_ready;
  assign inc_ovf = push && fifo_full && !pop;

  always_comb begin
    csum_err_d  = sat_inc(csum_err_q,  inc_csum);
    frame_err_d = sat_inc(frame_err_q, inc_frame);
    range_err_d = sat_inc(range_err_q, inc_range);
    ovf_err_d   = sat_inc(ovf_err_q,   inc_ovf);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= HUNT;
      x_q         <= '0;
      y_q         <= '0;
      pol_q       <= 1'b0;
      csum_q      <= '0;
      timer_q     <= '0;
      csum_err_q  <= '0;
      frame_err_q <= '0;
      range_err_q <= '0;
      ovf_err_q   <= '0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      pol_q       <= pol_d;
      csum_q      <= csum_d;
      timer_q     <= timer_d;
      csum_err_q  <= csum_err_d;
      frame_err_q <= frame_err_d;
      range_err_q <= range_err_d;
      ovf_err_q   <= ovf_err_d;
    end
  end

  event_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ('{x: x_q, y: y_q, pol: pol_q}),
    .full      (fifo_full),
    .pop       (pop),
    .head      (fifo_head),
    .empty     (fifo_empty)
  );

  assign ev_valid  = !fifo_empty;
  assign ev_x      = fifo_empty ? 8'h00 : fifo_head.x;
  assign ev_y      = fifo_empty ? 8'h00 : fifo_head.y;
  assign ev_pol    = fifo_empty ? 1'b0  : fifo_head.pol;
  assign csum_err  = csum_err_q;
  assign frame_err = frame_err_q;
  assign range_err = range_err_q;
  assign ovf_err   = ovf_err_q;

endmodule

// File: tb/tb_uart_event_decoder.sv
// Scoreboard bench for uart_event_decoder: stimulus queues expected events, a monitor checks transfers.
module tb_uart_event_decoder;
  import dvs_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic [7:0] ev_x, ev_y;
  logic       ev_pol, ev_valid, ev_ready;
  logic [7:0] csum_err, frame_err, range_err, ovf_err;

  dvs_event_t sb[$];
  int pass_cnt  = 0;
  int check_cnt = 0;

  always #5 clk = ~clk;

  uart_event_decoder dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .ev_x(ev_x), .ev_y(ev_y), .ev_pol(ev_pol), .ev_valid(ev_valid), .ev_ready(ev_ready),
    .csum_err(csum_err), .frame_err(frame_err), .range_err(range_err), .ovf_err(ovf_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    check_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Monitor: every accepted transfer must match the oldest expected event.
  initial begin
    dvs_event_t exp_ev;
    forever begin
      @(negedge clk);
      if (!rst && ev_valid && ev_ready) begin
        if (sb.size() == 0) begin
          check_cnt++;
          $display("FAIL unexpected_event: got x=0x%0h y=0x%0h pol=%0d, expected none", ev_x, ev_y, ev_pol);
        end else begin
          exp_ev = sb.pop_front();
          check("event", 32'({ev_x, ev_y, ev_pol}), 32'(exp_ev));
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    @(posedge clk); #1;
    in_data  = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (gap) @(posedge clk);
  endtask

  // Last byte is followed by no gap so the caller can observe first-event latency.
  task automatic send_pkt(input logic [7:0] b1, b2, b3, b4, input int gap);
    send_byte(DVS_SYNC_BYTE, gap);
    send_byte(b1, gap);
    send_byte(b2, gap);
    send_byte(b3, gap);
    send_byte(b4, 0);
  endtask

  task automatic expect_ev(input logic [7:0] x, y, input logic pol);
    sb.push_back('{x: x, y: y, pol: pol});
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
    check(name, 32'(sb.size()), 0);
  endtask

  task automatic check_errs(input string tag, input logic [7:0] c, f, r, o);
    @(negedge clk);
    check({tag, "_csum_err"},  csum_err,  c);
    check({tag, "_frame_err"}, frame_err, f);
    check({tag, "_range_err"}, range_err, r);
    check({tag, "_ovf_err"},   ovf_err,   o);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [7:0] t5_x [6] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
  logic [7:0] t5_y [6] = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16};
  logic       t5_p [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; ev_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_ev_valid", ev_valid, 0);
    check("reset_ev_fields", 32'({ev_x, ev_y, ev_pol}), 0);
    check_errs("reset", 0, 0, 0, 0);

    // 1: nominal packet at UART pacing; ev_valid the cycle after the checksum byte
    expect_ev(8'h10, 8'h20, 1'b1);
    send_pkt(8'h10, 8'h20, 8'h80, 8'hB0, 1040);
    @(negedge clk);
    check("t1_latency_ev_valid", ev_valid, 1);
    wait_drain("t1_drain");
    check_errs("t1", 0, 0, 0, 0);

    // 2: bad checksum then a good packet
    send_pkt(8'h10, 8'h20, 8'h80, 8'hB1, 10);
    check_errs("t2a", 1, 0, 0, 0);
    check("t2_no_event", ev_valid, 0);
    expect_ev(8'h01, 8'h02, 1'b0);
    send_pkt(8'h01, 8'h02, 8'h00, 8'h03, 10);
    wait_drain("t2_drain");

    // 3: garbage in HUNT is discarded silently
    send_byte(8'h00, 3);
    send_byte(8'hFF, 3);
    send_byte(8'h5A, 3);
    expect_ev(8'h10, 8'h20, 1'b1);
    send_pkt(8'h10, 8'h20, 8'h80, 8'hB0, 5);
    wait_drain("t3_drain");
    check_errs("t3", 1, 0, 0, 0);

    // 4: inter-byte timeout discards the partial packet
    send_byte(DVS_SYNC_BYTE, 5);
    send_byte(8'h10, 0);
    repeat (3000) @(posedge clk);
    check_errs("t4", 1, 1, 0, 0);
    check("t4_no_event", ev_valid, 0);
    expect_ev(8'h7F, 8'h7F, 1'b1);
    send_pkt(8'h7F, 8'h7F, 8'h80, 8'h80, 5);
    wait_drain("t4_drain");

    // 5: stalled consumer, six packets into a four-deep buffer
    @(posedge clk); #1 ev_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i < 4) expect_ev(t5_x[i], t5_y[i], t5_p[i]);
      send_pkt(t5_x[i], t5_y[i], {t5_p[i], 7'b0}, t5_x[i] ^ t5_y[i] ^ {t5_p[i], 7'b0}, 3);
    end
    check_errs("t5", 1, 1, 0, 2);
    check("t5_held_valid", ev_valid, 1);
    check("t5_held_head", 32'({ev_x, ev_y, ev_pol}), 32'({8'h01, 8'h11, 1'b1}));
    check("t5_held_count", 32'(sb.size()), 4);
    @(posedge clk); #1 ev_ready = 1'b1;
    wait_drain("t5_drain");
    repeat (2) @(negedge clk);
    check("t5_empty_after", ev_valid, 0);

    // 6: range error, mid-packet reset, counter saturation
    send_pkt(8'h90, 8'h10, 8'h00, 8'h80, 4);
    check_errs("t6a", 1, 1, 1, 2);
    check("t6_range_no_event", ev_valid, 0);
    @(posedge clk); #1 ev_ready = 1'b0;
    send_pkt(8'h33, 8'h44, 8'h80, 8'h33 ^ 8'h44 ^ 8'h80, 2);
    @(negedge clk);
    check("t6_pre_rst_valid", ev_valid, 1);
    send_byte(DVS_SYNC_BYTE, 2);
    send_byte(8'h10, 0);
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("t6_rst_ev_valid", ev_valid, 0);
    check("t6_rst_ev_fields", 32'({ev_x, ev_y, ev_pol}), 0);
    check_errs("t6_rst", 0, 0, 0, 0);
    @(posedge clk); #1 ev_ready = 1'b1;
    expect_ev(8'h05, 8'h06, 1'b1);
    send_pkt(8'h05, 8'h06, 8'h80, 8'h83, 2);
    wait_drain("t6_drain");
    for (int i = 0; i < 300; i++) send_pkt(8'h00, 8'h00, 8'h00, 8'h01, 1);
    check_errs("t6_sat", 8'hFF, 0, 0, 0);
    check("t6_sat_no_event", ev_valid, 0);

    repeat (4) @(negedge clk);
    check("final_sb_empty", 32'(sb.size()), 0);
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
